// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side buffer.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, ACK, WAIT} cap_state_t;

  // Bit positions inside the status register
  localparam int STAT_OVR     = 7;
  localparam int STAT_FULL    = 6;
  localparam int STAT_EMPTY   = 5;
  localparam int STAT_CNT_MSB = 3;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; push and pop are qualified internally so an
// empty pop is a no-op and a full push is accepted only alongside a real pop.
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH),
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              push_ok
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures bytes via rdy/clr_rdy,
// queues them, and serves a data/status read port with sticky overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  input  logic        rd_en,
  input  logic        rd_addr,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic        ovr,
  output logic [AW:0] count
);

  cap_state_t state, state_nxt;
  logic       push;
  logic       push_ok;
  logic       pop;
  logic [7:0] head;

  function automatic logic [7:0] status_byte(input logic o, input logic f,
                                             input logic e, input logic [AW:0] c);
    logic [7:0] s;
    s                 = '0;
    s[STAT_OVR]       = o;
    s[STAT_FULL]      = f;
    s[STAT_EMPTY]     = e;
    s[STAT_CNT_MSB:0] = 4'(c);
    return s;
  endfunction

  assign pop = rd_en & (rd_addr == REG_DATA);

  sync_fifo #(.DEPTH(DEPTH), .AW(AW), .DATA_W(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (rx_data),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .push_ok (push_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // WAIT holds off re-capture until the receiver's registered rdy has dropped
  always_comb begin
    state_nxt = state;
    clr_rdy   = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: if (rx_rdy) begin
        push      = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        clr_rdy   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (!rx_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Overrun set takes priority over the clear-on-status-read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr     <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      if (push & ~push_ok)                    ovr <= 1'b1;
      else if (rd_en && rd_addr == REG_STATUS) ovr <= 1'b0;
      if (rd_en) begin
        if (rd_addr == REG_STATUS) rd_data <= status_byte(ovr, full, empty, count);
        else                       rd_data <= empty ? 8'h00 : head;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=8).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rdy;
  logic       rd_en;
  logic       rd_addr;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       ovr;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DEPTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data),
    .clr_rdy (clr_rdy),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .ovr     (ovr),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    tick();
    rx_rdy = 1'b0;
    tick();
  endtask

  task automatic read_reg(input logic a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; rd_en = 1'b0; rd_addr = 1'b0;
    tick();
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_checks++; if (count !== 4'd0)    begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if ({empty, full, ovr, clr_rdy} !== 4'b1000) begin n_fail++; $display("FAIL reset_flags: got %b want 1000", {empty, full, ovr, clr_rdy}); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    rx_rdy = 1'b1; rx_data = 8'hA5;
    tick();
    n_checks++; if (count !== 4'd1)  begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    n_checks++; if (clr_rdy !== 1'b1) begin n_fail++; $display("FAIL single_ack_hi: got %b want 1", clr_rdy); end
    tick();
    n_checks++; if (clr_rdy !== 1'b0) begin n_fail++; $display("FAIL single_ack_lo: got %b want 0", clr_rdy); end
    tick();
    tick();
    n_checks++; if (count !== 4'd1 || clr_rdy !== 1'b0) begin n_fail++; $display("FAIL single_no_repush: got count %0d clr %b want 1 0", count, clr_rdy); end
    rx_rdy = 1'b0;
    tick();
    read_reg(1'b0);
    n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", rd_data); end
    n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL single_empty: got %b want 1", empty); end
    tick();
    n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got %h want a5", rd_data); end
  endtask

  task automatic test_empty_read();
    read_reg(1'b0);
    n_checks++; if (rd_data !== 8'h00 || count !== 4'd0) begin n_fail++; $display("FAIL empty_data: got %h cnt %0d want 00 0", rd_data, count); end
    read_reg(1'b1);
    n_checks++; if (rd_data !== 8'h20) begin n_fail++; $display("FAIL empty_status: got %h want 20", rd_data); end
    push_byte(8'h33);
    read_reg(1'b0);
    n_checks++; if (rd_data !== 8'h33) begin n_fail++; $display("FAIL empty_ptrs: got %h want 33", rd_data); end
  endtask

  task automatic test_fill_overrun();
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d want 8", count); end
    n_checks++; if (full !== 1'b1 || ovr !== 1'b1) begin n_fail++; $display("FAIL fill_flags: got full %b ovr %b want 1 1", full, ovr); end
    read_reg(1'b1);
    n_checks++; if (rd_data !== 8'hC8) begin n_fail++; $display("FAIL fill_status: got %h want c8", rd_data); end
    n_checks++; if (ovr !== 1'b0)      begin n_fail++; $display("FAIL fill_ovr_clr: got %b want 0", ovr); end
    for (int i = 1; i <= 8; i++) begin
      read_reg(1'b0);
      n_checks++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL fill_order[%0d]: got %h want %h", i, rd_data, 8'(i)); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained: got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      push_byte(8'(8'h40 + i));
      n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want 1", i, count); end
      read_reg(1'b0);
      n_checks++; if (rd_data !== 8'(8'h40 + i)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, rd_data, 8'(8'h40 + i)); end
    end
    n_checks++; if (ovr !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL wrap_end: got ovr %b cnt %0d want 0 0", ovr, count); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
    rx_rdy = 1'b1; rx_data = 8'h5A; rd_en = 1'b1; rd_addr = 1'b0;
    tick();
    rd_en = 1'b0;
    n_checks++; if (rd_data !== 8'h10) begin n_fail++; $display("FAIL fpp_head: got %h want 10", rd_data); end
    n_checks++; if (count !== 4'd8 || ovr !== 1'b0) begin n_fail++; $display("FAIL fpp_state: got cnt %0d ovr %b want 8 0", count, ovr); end
    tick();
    rx_rdy = 1'b0;
    tick();
    for (int i = 1; i < 8; i++) begin
      read_reg(1'b0);
      n_checks++; if (rd_data !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL fpp_order[%0d]: got %h want %h", i, rd_data, 8'(8'h10 + i)); end
    end
    read_reg(1'b0);
    n_checks++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL fpp_last: got %h want 5a", rd_data); end
  endtask

  task automatic test_reset_mid_ack();
    for (int i = 0; i < 8; i++) push_byte(8'(8'h60 + i));
    rx_rdy = 1'b1; rx_data = 8'h77;
    tick();
    n_checks++; if (clr_rdy !== 1'b1 || ovr !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got clr %b ovr %b want 1 1", clr_rdy, ovr); end
    rst = 1'b1;
    #1;
    n_checks++; if (clr_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_clr: got %b want 0", clr_rdy); end
    n_checks++; if (count !== 4'd0 || ovr !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL rst_state: got cnt %0d ovr %b empty %b want 0 0 1", count, ovr, empty); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (count !== 4'd1 || clr_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_recap: got cnt %0d clr %b want 1 1", count, clr_rdy); end
    tick();
    tick();
    n_checks++; if (count !== 4'd1 || clr_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_once: got cnt %0d clr %b want 1 0", count, clr_rdy); end
    rx_rdy = 1'b0;
    tick();
    read_reg(1'b0);
    n_checks++; if (rd_data !== 8'h77) begin n_fail++; $display("FAIL rst_data: got %h want 77", rd_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty_read();
    test_fill_overrun();
    test_wrap();
    test_full_push_pop();
    test_reset_mid_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
